// File: rtl/midi_pkg.sv
// Shared constants and parser state encoding for the MIDI note parser.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF = 4'h8;
  localparam logic [3:0] ST_NOTE_ON  = 4'h9;
  localparam logic [3:0] ST_CC       = 4'hB;
  localparam logic [3:0] SYS_PREFIX  = 4'hF;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_KEY,
    S_VEL
  } parser_state_t;

endpackage

// File: rtl/midi_note_parser.sv
// Monophonic, last-note-priority MIDI parser: turns the UART byte stream into
// registered NOTE/VELOCITY/GATE plus a one-cycle strobe per accepted note-on.
module midi_note_parser
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] MIDI_DATA,
  input  logic       MIDI_VALID,
  output logic [7:0] NOTE,
  output logic [6:0] VELOCITY,
  output logic       GATE,
  output logic       NOTE_STB
);

  localparam logic [3:0] CHAN = 4'(CHANNEL);

  parser_state_t state;
  logic [3:0]    msg_type;
  logic [6:0]    key;

  logic       is_realtime;
  logic       is_status;
  logic [3:0] status_hi;
  logic       chan_ok;
  logic       type_ok;
  logic [6:0] data7;

  assign is_realtime = (MIDI_DATA >= RT_MIN);
  assign is_status   = MIDI_DATA[7];
  assign status_hi   = MIDI_DATA[7:4];
  assign data7       = MIDI_DATA[6:0];
  assign chan_ok     = OMNI || (MIDI_DATA[3:0] == CHAN);
  assign type_ok     = (status_hi == ST_NOTE_OFF) || (status_hi == ST_NOTE_ON) ||
                       (status_hi == ST_CC);

  // Real-time bytes are invisible to the parser so they can interleave freely.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      msg_type <= 4'h0;
      key      <= 7'd0;
      NOTE     <= 8'd0;
      VELOCITY <= 7'd0;
      GATE     <= 1'b0;
      NOTE_STB <= 1'b0;
    end else begin
      NOTE_STB <= 1'b0;
      if (MIDI_VALID && !is_realtime) begin
        if (is_status) begin
          if (status_hi != SYS_PREFIX && type_ok && chan_ok) begin
            msg_type <= status_hi;
            state    <= S_KEY;
          end else begin
            msg_type <= 4'h0;
            state    <= S_SKIP;
          end
        end else begin
          case (state)
            S_KEY: begin
              key   <= data7;
              state <= S_VEL;
            end
            S_VEL: begin
              state <= S_KEY;
              if (msg_type == ST_NOTE_ON && data7 != 7'd0) begin
                NOTE     <= {1'b0, key};
                VELOCITY <= data7;
                GATE     <= 1'b1;
                NOTE_STB <= 1'b1;
              end else if (msg_type == ST_NOTE_ON || msg_type == ST_NOTE_OFF) begin
                // Release keeps NOTE/VELOCITY so the decaying voice holds its pitch.
                if (GATE && ({1'b0, key} == NOTE))
                  GATE <= 1'b0;
              end else if (msg_type == ST_CC) begin
                if (key == CC_ALL_NOTES_OFF || key == CC_ALL_SOUND_OFF)
                  GATE <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/midi_note_parser.md
Name: midi_note_parser

Overview:
Parses the received MIDI byte stream from the UART receiver. Produces the registered NOTE number, GATE, VELOCITY and a new-note strobe. NOTE feeds the note-to-phase-increment table directly, which in turn drives the phase accumulator. Monophonic, last-note priority, single channel or omni.

Parameters:
CHANNEL, 0, MIDI channel to accept (0..15, encoded value of status low nibble).
OMNI, 0, 1 = accept note/CC messages on any channel; CHANNEL is then ignored.

Ports:
CLK  input  1  system clock; all state updates on posedge.
RESET  input  1  asynchronous, active-low reset.
MIDI_DATA  input  8  received MIDI byte; sampled only when MIDI_VALID=1.
MIDI_VALID  input  1  one-cycle strobe per received byte; may be high on consecutive cycles.
NOTE  output  8  current key number 0..127, bit 7 always 0; consumed by note-to-phase table.
VELOCITY  output  7  velocity of the current note.
GATE  output  1  1 while the current note is held.
NOTE_STB  output  1  one-cycle pulse for each accepted note-on.

Behaviour:
- Reset (RESET=0, async): NOTE=0, VELOCITY=0, GATE=0, NOTE_STB=0, state=S_IDLE, stored message type cleared. All outputs are registered.
- Only cycles with MIDI_VALID=1 advance the parser. NOTE_STB is forced to 0 on every cycle it is not being pulsed.
- Byte classes:
  - Real-time (0xF8..0xFF): ignored completely. No state change, and the in-progress message is not disturbed.
  - System common / SysEx (0xF0..0xF7): go to S_SKIP and clear running status.
  - Channel status (0x80..0xEF):
    - 0x8n (note-off), 0x9n (note-on) or 0xBn (control change) with matching channel: store type, go to S_KEY.
    - Any other channel status, or a non-matching channel: go to S_SKIP.
  - Data (bit7=0): handled per state.
- States:
  - S_IDLE: data bytes ignored.
  - S_SKIP: data bytes discarded. Stays in S_SKIP until the next non-real-time status byte.
  - S_KEY: data byte is latched as key, go to S_VEL.
  - S_VEL: data byte is latched as value, the message is executed, go back to S_KEY (running status).
- A status byte arriving in S_KEY or S_VEL aborts the partial message with no output change. That status byte is then processed normally.
- Execute rules:
  - Note-on with value>0: NOTE<=key, VELOCITY<=value, GATE<=1, NOTE_STB=1 for one cycle. Retrigger while GATE=1 is allowed (last-note priority).
  - Note-off, or note-on with value=0:
    - If GATE=1 and key==NOTE: GATE<=0. NOTE and VELOCITY are held so the release keeps its pitch.
    - Otherwise no change.
  - CC with key=123 (all notes off) or key=120 (all sound off): GATE<=0, any value. Other CC numbers: no change.
- Latency: outputs update on the CLK edge that samples the final data byte, so they are visible one cycle later.
- Same-edge note-on and note-off cannot occur (one byte per cycle). An async reset mid-message discards the partial message.

Decomposition:
- Shared package midi_pkg:
  - Status constants: ST_NOTE_OFF=4'h8, ST_NOTE_ON=4'h9, ST_CC=4'hB, SYS_PREFIX=4'hF, RT_MIN=8'hF8.
  - CC constants: CC_ALL_SOUND_OFF=120, CC_ALL_NOTES_OFF=123.
  - Parser state enum: S_IDLE, S_SKIP, S_KEY, S_VEL.
- No sub-module. A single FSM plus output registers is the natural size.

Test Plan:
1. Reset, then bytes 0x90,0x3C,0x64 (CHANNEL=0) -> NOTE=60, VELOCITY=100, GATE=1, one NOTE_STB pulse one cycle after the 0x64 byte.
2. Running status: after scenario 1, bytes 0x40,0x50 then 0x3C,0x00 -> NOTE=64, VEL=80, GATE=1, STB pulse. The vel-0 for key 60 then leaves GATE=1 (key mismatch). A following 0x80,0x40,0x00 -> GATE=0 with NOTE still 64.
3. Real-time interleave: 0x90,0xF8,0x45,0xFE,0x70 -> NOTE=69, VEL=112, GATE=1. Timing bytes have no effect.
4. Channel filter: CHANNEL=0, OMNI=0, bytes 0x91,0x30,0x7F -> no output change, no STB. Same test with OMNI=1 -> NOTE=48, GATE=1.
5. Abort / skip:
  - 0x90,0x3C,0xF0,0x01,0x02,0xF7,0x3C,0x40 -> no output change (SysEx skipped, running status cleared).
  - Then 0xB0,0x7B,0x00 while GATE=1 -> GATE=0.
6. Async reset asserted between key and velocity bytes with MIDI_VALID back-to-back -> outputs reset immediately. Subsequent lone 0x40 data byte is ignored (S_IDLE).
